seq_pattern_tx: RTL and testbench

Serial pattern transmitter that generates the bitstreams our serial sequence detectors consume. It loads a PAT_W-bit pattern and a repetition count on a start request. It then shifts the pattern out MSB-first, one bit per clock, repeated the requested number of times, with an optional fixed gap of idle zeros between repetitions. It is the stimulus/transmit end of the serial-pattern interface and reports busy, per-repetition progress and completion.

---
 rtl/seq_pattern_tx.sv | 152 +++++++++++++++
 tb/tb_seq_pattern_tx.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a captured PAT_W-bit pattern out MSB-first,
// repeated reps times, with GAP_LEN idle cycles between repetitions; all outputs registered.
module seq_pattern_tx #(
    parameter int PAT_W   = 4,
    parameter int CNT_W   = 4,
    parameter int GAP_LEN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] reps,
    input  logic             abort,
    output logic             dout,
    output logic             dvalid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] tx_count
);

    localparam int BC_W  = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0] GAP_INIT = (GAP_LEN > 0) ? GAP_W'(GAP_LEN - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] shreg_q, shreg_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] tx_count_q, tx_count_d;
    logic             dout_q, dout_d;
    logic             dvalid_q, dvalid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            pat_q      <= '0;
            bit_cnt_q  <= '0;
            rem_q      <= '0;
            gap_q      <= '0;
            tx_count_q <= '0;
            dout_q     <= 1'b0;
            dvalid_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            pat_q      <= pat_d;
            bit_cnt_q  <= bit_cnt_d;
            rem_q      <= rem_d;
            gap_q      <= gap_d;
            tx_count_q <= tx_count_d;
            dout_q     <= dout_d;
            dvalid_q   <= dvalid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        pat_d      = pat_q;
        bit_cnt_d  = bit_cnt_q;
        rem_d      = rem_q;
        gap_d      = gap_q;
        tx_count_d = tx_count_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d      = pattern;
                    tx_count_d = '0;
                    if (reps != '0) begin
                        state_d   = SHIFT;
                        shreg_d   = pattern;
                        bit_cnt_d = BIT_LAST;
                        rem_d     = reps - CNT_W'(1);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                // abort wins over the end-of-repetition update, so tx_count holds
                if (abort) begin
                    state_d = IDLE;
                end else if (bit_cnt_q != '0) begin
                    shreg_d   = {shreg_q[PAT_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - BC_W'(1);
                end else begin
                    tx_count_d = (tx_count_q == CNT_MAX) ? tx_count_q : tx_count_q + CNT_W'(1);
                    if (rem_q == '0) begin
                        state_d = DONE;
                    end else if (GAP_LEN == 0) begin
                        shreg_d   = pat_q;
                        bit_cnt_d = BIT_LAST;
                        rem_d     = rem_q - CNT_W'(1);
                    end else begin
                        state_d = GAP;
                        gap_d   = GAP_INIT;
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (gap_q == '0) begin
                    state_d   = SHIFT;
                    shreg_d   = pat_q;
                    bit_cnt_d = BIT_LAST;
                    rem_d     = rem_q - CNT_W'(1);
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered views of the state being entered
        dvalid_d = (state_d == SHIFT);
        dout_d   = (state_d == SHIFT) && shreg_d[PAT_W-1];
        busy_d   = (state_d == SHIFT) || (state_d == GAP);
        done_d   = (state_d == DONE);
    end

    assign dout     = dout_q;
    assign dvalid   = dvalid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign tx_count = tx_count_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: one back-to-back instance and one with a 2-cycle gap,
// checked cycle by cycle against an expected-output queue built from the stimulus.
module tb_seq_pattern_tx;

    logic       clk;
    logic       rst;
    logic       start_a, start_b;
    logic [3:0] pattern;
    logic [3:0] reps;
    logic       abort;

    logic       dout_a, dvalid_a, busy_a, done_a;
    logic [3:0] tx_count_a;
    logic       dout_b, dvalid_b, busy_b, done_b;
    logic [3:0] tx_count_b;

    typedef struct packed {
        logic       dout;
        logic       dvalid;
        logic       busy;
        logic       done;
        logic [3:0] tx;
    } exp_t;

    exp_t sb_q[$];
    int   num_cmp;
    int   num_err;

    seq_pattern_tx #(.PAT_W(4), .CNT_W(4), .GAP_LEN(0)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .pattern(pattern), .reps(reps),
        .abort(abort), .dout(dout_a), .dvalid(dvalid_a), .busy(busy_a),
        .done(done_a), .tx_count(tx_count_a)
    );

    seq_pattern_tx #(.PAT_W(4), .CNT_W(4), .GAP_LEN(2)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .pattern(pattern), .reps(reps),
        .abort(abort), .dout(dout_b), .dvalid(dvalid_b), .busy(busy_b),
        .done(done_b), .tx_count(tx_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        num_cmp++;
        if (obs !== exp_v) begin
            num_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t mk(input logic d, input logic v, input logic b,
                                input logic dn, input logic [3:0] tx);
        exp_t e;
        e.dout = d; e.dvalid = v; e.busy = b; e.done = dn; e.tx = tx;
        return e;
    endfunction

    // Expected outputs for each cycle after the accepting edge; cut truncates the
    // stream (abort or reset presented during output cycle cut).
    task automatic gen(input logic [3:0] pat, input int nreps, input int gap,
                       input int cut, input bit cut_rst);
        exp_t full[$];
        for (int r = 0; r < nreps; r++) begin
            for (int b = 0; b < 4; b++)
                full.push_back(mk(pat[3-b], 1'b1, 1'b1, 1'b0, 4'(r)));
            if (r < nreps - 1)
                for (int g = 0; g < gap; g++)
                    full.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 4'(r + 1)));
        end
        full.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 4'(nreps)));
        full.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'(nreps)));
        if (cut >= 0 && cut < full.size()) begin
            for (int k = 0; k <= cut; k++) sb_q.push_back(full[k]);
            sb_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, cut_rst ? 4'd0 : full[cut].tx));
        end else begin
            foreach (full[k]) sb_q.push_back(full[k]);
        end
    endtask

    task automatic step(input bit use_b, input int idx, input string name);
        exp_t e, o;
        @(posedge clk);
        #1;
        if (use_b) o = mk(dout_b, dvalid_b, busy_b, done_b, tx_count_b);
        else       o = mk(dout_a, dvalid_a, busy_a, done_a, tx_count_a);
        e = sb_q.pop_front();
        check($sformatf("%s_cyc%0d", name, idx), 32'(o), 32'(e));
    endtask

    // poke: after output cycle poke, pulse start with a different pattern
    task automatic run(input string name, input logic [3:0] pat, input logic [3:0] nreps,
                       input bit use_b, input int cut, input bit cut_rst, input int poke);
        int idx;
        gen(pat, int'(nreps), use_b ? 2 : 0, cut, cut_rst);
        pattern = pat;
        reps    = nreps;
        start_a = !use_b;
        start_b = use_b;
        idx     = 0;
        while (sb_q.size() > 0) begin
            step(use_b, idx, name);
            start_a = 1'b0; start_b = 1'b0; abort = 1'b0; rst = 1'b0;
            if (idx == cut) begin
                if (cut_rst) rst = 1'b1;
                else         abort = 1'b1;
            end
            if (idx == poke) begin
                pattern = 4'b1111;
                reps    = 4'd1;
                if (use_b) start_b = 1'b1;
                else       start_a = 1'b1;
            end
            idx++;
        end
    endtask

    initial begin
        num_cmp = 0;
        num_err = 0;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; pattern = '0; reps = '0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_a", 32'({dout_a, dvalid_a, busy_a, done_a, tx_count_a}), 32'd0);
        check("reset_b", 32'({dout_b, dvalid_b, busy_b, done_b, tx_count_b}), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run("basic",     4'b1010, 4'd2, 1'b0, -1, 1'b0, -1);
        run("gap",       4'b1100, 4'd2, 1'b1, -1, 1'b0, -1);
        run("reps0",     4'b1010, 4'd0, 1'b0, -1, 1'b0, -1);
        run("reps0_gap", 4'b0110, 4'd0, 1'b1, -1, 1'b0, -1);
        run("rst_mid",   4'b1010, 4'd3, 1'b0,  4, 1'b1, -1);
        run("busy_ign",  4'b1010, 4'd1, 1'b0, -1, 1'b0,  1);
        run("busy_ign_b",4'b1010, 4'd1, 1'b1, -1, 1'b0,  2);
        run("done_ign",  4'b1010, 4'd1, 1'b0, -1, 1'b0,  4);
        run("fresh",     4'b1111, 4'd1, 1'b0, -1, 1'b0, -1);
        run("abort",     4'b1011, 4'd3, 1'b0,  6, 1'b0, -1);
        run("abort_gap", 4'b1011, 4'd3, 1'b1,  4, 1'b0, -1);
        run("abort_end", 4'b0111, 4'd2, 1'b0,  3, 1'b0, -1);
        run("sat",       4'b1001, 4'd15, 1'b0, -1, 1'b0, -1);
        run("gap3",      4'b0101, 4'd3, 1'b1, -1, 1'b0, -1);
        for (int i = 0; i < 6; i++) begin
            run($sformatf("rnd%0d", i), 4'($urandom), 4'($urandom_range(0, 5)),
                1'($urandom), -1, 1'b0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_cmp, num_err);
        $finish;
    end

endmodule
